attribute_palette: RTL

Programmable text-mode colour stage for the HDMI pixel pipeline: turns a per-character 8-bit attribute plus a glyph pixel bit into 24-bit RGB. Successor to the fixed 16-colour attribute lookup: palette width is parametrised, all 16 entries are writable at run time, attribute bit 7 is mode-selectable (blink or bright background), and a cursor inversion input is added. Sits between the glyph/font stage and the HDMI TMDS encoder, on the pixel clock.

---
 rtl/attribute_palette.sv | 122 ++++++++++++
 1 files changed

// File: rtl/attribute_palette.sv
// attribute_palette: text-mode colour stage between the glyph/font stage and
// the TMDS encoder. A per-character attribute plus a glyph bit index a 16-entry
// run-time writable palette through a two-register pipeline on the pixel clock.
module attribute_palette #(
  parameter int COLOR_W  = 8,
  parameter int FRAME_W  = 6,
  parameter int BLINK_ON = 30
) (
  input  logic                 clk_hdmi_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic                 pixel_in,
  input  logic [7:0]           attribute_in,
  input  logic                 cursor_in,
  input  logic [FRAME_W-1:0]   frame_count_in,
  input  logic                 blink_mode_in,
  input  logic                 pal_we_in,
  input  logic [3:0]           pal_addr_in,
  input  logic [3*COLOR_W-1:0] pal_data_in,
  output logic [COLOR_W-1:0]   red_out,
  output logic [COLOR_W-1:0]   green_out,
  output logic [COLOR_W-1:0]   blue_out,
  output logic                 valid_out
);

  localparam int RGB_W = 3 * COLOR_W;

  // Place an 8-bit channel value in the top bits of a COLOR_W channel:
  // wider channels get zero LSBs, narrower ones drop LSBs.
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [7:0] v);
    logic [COLOR_W+7:0] wide;
    wide = {v, {COLOR_W{1'b0}}};
    return wide[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic [RGB_W-1:0] pal_default(input logic [3:0] idx);
    logic [23:0] rgb8;
    case (idx)
      4'h0:    rgb8 = 24'h000000;
      4'h1:    rgb8 = 24'h800000;
      4'h2:    rgb8 = 24'h008000;
      4'h3:    rgb8 = 24'h808000;
      4'h4:    rgb8 = 24'h000080;
      4'h5:    rgb8 = 24'h800080;
      4'h6:    rgb8 = 24'h008080;
      4'h7:    rgb8 = 24'hC0C0C0;
      4'h8:    rgb8 = 24'h808080;
      4'h9:    rgb8 = 24'hFF0000;
      4'hA:    rgb8 = 24'h00FF00;
      4'hB:    rgb8 = 24'hFFFF00;
      4'hC:    rgb8 = 24'h0000FF;
      4'hD:    rgb8 = 24'hFF00FF;
      4'hE:    rgb8 = 24'h00FFFF;
      default: rgb8 = 24'hFFFFFF;
    endcase
    return {scale_chan(rgb8[23:16]), scale_chan(rgb8[15:8]), scale_chan(rgb8[7:0])};
  endfunction

  logic [RGB_W-1:0] pal_q [16];

  logic       s1_valid_q, s1_pixel_q, s1_cursor_q, s1_blink_q;
  logic [3:0] s1_fg_q, s1_bg_q;
  logic [3:0] s1_bg_d;
  logic       s1_blink_d;

  logic             sel_fg;
  logic [3:0]       rd_idx;
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic             valid_q;

  // Stage-1 decode: background index source and whether blink hides the glyph.
  always_comb begin
    s1_bg_d    = blink_mode_in ? {1'b0, attribute_in[6:4]} : attribute_in[7:4];
    s1_blink_d = blink_mode_in & attribute_in[7] &
                 (32'(frame_count_in) < 32'(BLINK_ON));
  end

  // Stage-2 colour select: blink blanks the glyph first, cursor inverts after.
  always_comb begin
    sel_fg = (s1_blink_q ? 1'b0 : s1_pixel_q) ^ s1_cursor_q;
    rd_idx = sel_fg ? s1_fg_q : s1_bg_q;
    rgb_d  = s1_valid_q ? pal_q[rd_idx] : '0;
  end

  // Palette storage; reset reloads defaults and beats a simultaneous write.
  always_ff @(posedge clk_hdmi_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= pal_default(4'(i));
    end else if (pal_we_in) begin
      pal_q[pal_addr_in] <= pal_data_in;
    end
  end

  // Pipeline registers for both stages; reset drops any in-flight pixels.
  always_ff @(posedge clk_hdmi_in) begin
    if (rst_in) begin
      s1_valid_q  <= 1'b0;
      s1_pixel_q  <= 1'b0;
      s1_cursor_q <= 1'b0;
      s1_blink_q  <= 1'b0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      rgb_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      s1_valid_q  <= valid_in;
      s1_pixel_q  <= pixel_in;
      s1_cursor_q <= cursor_in;
      s1_blink_q  <= s1_blink_d;
      s1_fg_q     <= attribute_in[3:0];
      s1_bg_q     <= s1_bg_d;
      rgb_q       <= rgb_d;
      valid_q     <= s1_valid_q;
    end
  end

  assign red_out   = rgb_q[RGB_W-1 -: COLOR_W];
  assign green_out = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue_out  = rgb_q[COLOR_W-1:0];
  assign valid_out = valid_q;

endmodule
